// File: rtl/digit_row_streamer.sv
// digit_row_streamer: renders a multi-digit BCD value as a scaled 4x6 font
// bitmap and streams it one pixel row per valid/ready handshake.
module digit_row_streamer #(
    parameter int NUM_DIGITS = 2,
    parameter int HSCALE     = 5,
    parameter int VSCALE     = 1,
    parameter int GAP        = 0,
    parameter int LZ_BLANK   = 1,
    localparam int GW        = 4 * HSCALE,
    localparam int SW        = GW + GAP,
    localparam int W         = NUM_DIGITS * SW,
    localparam int R         = 6 * VSCALE,
    localparam int IW        = (R > 1) ? $clog2(R) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [4*NUM_DIGITS-1:0] in_bcd,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [W-1:0]            out_row,
    output logic [IW-1:0]           out_row_idx,
    output logic                    out_last
);

    localparam int VCW = (VSCALE > 1) ? $clog2(VSCALE) : 1;

    typedef enum logic {S_IDLE, S_EMIT} state_t;

    state_t                  r_state;
    logic [4*NUM_DIGITS-1:0] r_bcd;
    logic [NUM_DIGITS-1:0]   r_blank;
    logic [W-1:0]            r_row;
    logic [IW-1:0]           r_idx;
    logic [2:0]              r_frow;
    logic [VCW-1:0]          r_vcnt;
    logic                    r_in_ready;
    logic                    r_out_valid;
    logic                    r_last;

    logic [NUM_DIGITS-1:0]   w_blank;
    logic                    w_lead_zero;
    logic [VCW-1:0]          w_vcnt_nx;
    logic [2:0]              w_frow_nx;
    logic [IW-1:0]           w_idx_nx;
    logic                    w_last_nx;

    // One font nibble (MSB = leftmost column); codes 10..15 are blank.
    function automatic logic [3:0] font_nib(input logic [3:0] dig,
                                            input logic [2:0] frow);
        logic [23:0] g;
        case (dig)
            4'd0:    g = 24'h699996;
            4'd1:    g = 24'h26A22F;
            4'd2:    g = 24'h69168F;
            4'd3:    g = 24'h692196;
            4'd4:    g = 24'h359F11;
            4'd5:    g = 24'hF8E196;
            4'd6:    g = 24'h698E96;
            4'd7:    g = 24'hF12488;
            4'd8:    g = 24'h696996;
            4'd9:    g = 24'h697196;
            default: g = 24'h000000;
        endcase
        case (frow)
            3'd0:    font_nib = g[23:20];
            3'd1:    font_nib = g[19:16];
            3'd2:    font_nib = g[15:12];
            3'd3:    font_nib = g[11:8];
            3'd4:    font_nib = g[7:4];
            3'd5:    font_nib = g[3:0];
            default: font_nib = 4'h0;
        endcase
    endfunction

    // Full pixel row: each font bit widened HSCALE times, GAP zeros on the right.
    function automatic logic [W-1:0] render(input logic [4*NUM_DIGITS-1:0] bcd,
                                            input logic [NUM_DIGITS-1:0]   blank,
                                            input logic [2:0]              frow);
        logic [3:0] nib;
        render = '0;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            nib = blank[d] ? 4'h0 : font_nib(bcd[4*d +: 4], frow);
            for (int j = 0; j < GW; j++) begin
                render[d*SW + GAP + j] = nib[j / HSCALE];
            end
        end
    endfunction

    // Leading-zero mask: a digit blanks when it and all digits above are zero.
    always_comb begin
        w_blank     = '0;
        w_lead_zero = 1'b1;
        for (int d = NUM_DIGITS - 1; d >= 0; d--) begin
            w_lead_zero = w_lead_zero & (in_bcd[4*d +: 4] == 4'd0);
            if (d != 0 && LZ_BLANK != 0) begin
                w_blank[d] = w_lead_zero;
            end
        end
    end

    // Next row position: VSCALE repeats of each font row.
    always_comb begin
        if (r_vcnt == VCW'(VSCALE - 1)) begin
            w_vcnt_nx = '0;
            w_frow_nx = r_frow + 3'd1;
        end else begin
            w_vcnt_nx = r_vcnt + VCW'(1);
            w_frow_nx = r_frow;
        end
        w_idx_nx  = r_idx + IW'(1);
        w_last_nx = (w_idx_nx == IW'(R - 1));
    end

    // Capture/emit FSM with all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_bcd       <= '0;
            r_blank     <= '0;
            r_row       <= '0;
            r_idx       <= '0;
            r_frow      <= '0;
            r_vcnt      <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_last      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_bcd       <= in_bcd;
                        r_blank     <= w_blank;
                        r_row       <= render(in_bcd, w_blank, 3'd0);
                        r_idx       <= '0;
                        r_frow      <= '0;
                        r_vcnt      <= '0;
                        r_in_ready  <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_last      <= (R == 1);
                        r_state     <= S_EMIT;
                    end
                end
                S_EMIT: begin
                    if (out_ready) begin
                        if (r_last) begin
                            r_out_valid <= 1'b0;
                            r_last      <= 1'b0;
                            r_in_ready  <= 1'b1;
                            r_state     <= S_IDLE;
                        end else begin
                            r_row  <= render(r_bcd, r_blank, w_frow_nx);
                            r_idx  <= w_idx_nx;
                            r_frow <= w_frow_nx;
                            r_vcnt <= w_vcnt_nx;
                            r_last <= w_last_nx;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = r_out_valid;
    assign out_row     = r_row;
    assign out_row_idx = r_idx;
    assign out_last    = r_last;

endmodule

// File: tb/tb_digit_row_streamer.sv
// tb_digit_row_streamer: scoreboard bench for digit_row_streamer,
// default instance plus a 3-digit, VSCALE=2, GAP=2, no-blanking instance.
module tb_digit_row_streamer;

    typedef struct {
        logic [65:0] row;
        int          idx;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        a_in_valid = 1'b0;
    logic        a_in_ready;
    logic [7:0]  a_in_bcd = '0;
    logic        a_out_valid;
    logic        a_out_ready = 1'b1;
    logic [39:0] a_out_row;
    logic [2:0]  a_out_row_idx;
    logic        a_out_last;

    logic        b_in_valid = 1'b0;
    logic        b_in_ready;
    logic [11:0] b_in_bcd = '0;
    logic        b_out_valid;
    logic        b_out_ready = 1'b1;
    logic [65:0] b_out_row;
    logic [3:0]  b_out_row_idx;
    logic        b_out_last;

    int n_checks = 0;
    int n_fail   = 0;
    exp_t qa[$];
    exp_t qb[$];

    always #5 clk = ~clk;

    digit_row_streamer u_dut_a (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (a_in_valid),
        .in_ready    (a_in_ready),
        .in_bcd      (a_in_bcd),
        .out_valid   (a_out_valid),
        .out_ready   (a_out_ready),
        .out_row     (a_out_row),
        .out_row_idx (a_out_row_idx),
        .out_last    (a_out_last)
    );

    digit_row_streamer #(
        .NUM_DIGITS (3),
        .HSCALE     (5),
        .VSCALE     (2),
        .GAP        (2),
        .LZ_BLANK   (0)
    ) u_dut_b (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (b_in_valid),
        .in_ready    (b_in_ready),
        .in_bcd      (b_in_bcd),
        .out_valid   (b_out_valid),
        .out_ready   (b_out_ready),
        .out_row     (b_out_row),
        .out_row_idx (b_out_row_idx),
        .out_last    (b_out_last)
    );

    task automatic chk(input string name, input logic [65:0] act,
                       input logic [65:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Monitor for the default instance.
    always @(negedge clk) begin : mon_a
        exp_t e;
        if (rst_n && a_out_valid && a_out_ready) begin
            if (qa.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL a_unexpected_row actual_idx=%0d expected=none",
                         a_out_row_idx);
            end else begin
                e = qa.pop_front();
                chk("a_row", 66'(a_out_row), e.row);
                chk("a_idx", 66'(a_out_row_idx), 66'(e.idx));
                chk("a_last", 66'(a_out_last), 66'(e.idx == 5));
            end
        end
    end

    // Monitor for the 3-digit instance.
    always @(negedge clk) begin : mon_b
        exp_t e;
        if (rst_n && b_out_valid && b_out_ready) begin
            if (qb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL b_unexpected_row actual_idx=%0d expected=none",
                         b_out_row_idx);
            end else begin
                e = qb.pop_front();
                chk("b_row", b_out_row, e.row);
                chk("b_idx", 66'(b_out_row_idx), 66'(e.idx));
                chk("b_last", 66'(b_out_last), 66'(e.idx == 11));
            end
        end
    end

    task automatic push_a(input logic [39:0] r0, input logic [39:0] r1,
                          input logic [39:0] r2, input logic [39:0] r3,
                          input logic [39:0] r4, input logic [39:0] r5);
        qa.push_back('{66'(r0), 0});
        qa.push_back('{66'(r1), 1});
        qa.push_back('{66'(r2), 2});
        qa.push_back('{66'(r3), 3});
        qa.push_back('{66'(r4), 4});
        qa.push_back('{66'(r5), 5});
    endtask

    function automatic logic [65:0] rb(input logic [19:0] g2,
                                       input logic [19:0] g1,
                                       input logic [19:0] g0);
        return {g2, 2'b00, g1, 2'b00, g0, 2'b00};
    endfunction

    task automatic push_b(input logic [65:0] f0, input logic [65:0] f1,
                          input logic [65:0] f2, input logic [65:0] f3,
                          input logic [65:0] f4, input logic [65:0] f5);
        logic [65:0] f[6];
        f = '{f0, f1, f2, f3, f4, f5};
        for (int i = 0; i < 6; i++) begin
            qb.push_back('{f[i], 2*i});
            qb.push_back('{f[i], 2*i + 1});
        end
    endtask

    task automatic send_a(input logic [7:0] v);
        @(posedge clk);
        #1;
        chk("a_in_ready_idle", 66'(a_in_ready), 66'd1);
        a_in_valid = 1'b1;
        a_in_bcd   = v;
        @(posedge clk);
        #1;
        a_in_valid = 1'b0;
        chk("a_lat_valid", 66'(a_out_valid), 66'd1);
        chk("a_lat_idx", 66'(a_out_row_idx), 66'd0);
        chk("a_in_ready_busy", 66'(a_in_ready), 66'd0);
    endtask

    task automatic send_b(input logic [11:0] v);
        @(posedge clk);
        #1;
        chk("b_in_ready_idle", 66'(b_in_ready), 66'd1);
        b_in_valid = 1'b1;
        b_in_bcd   = v;
        @(posedge clk);
        #1;
        b_in_valid = 1'b0;
        chk("b_lat_valid", 66'(b_out_valid), 66'd1);
        chk("b_lat_idx", 66'(b_out_row_idx), 66'd0);
    endtask

    task automatic wait_a;
        for (int i = 0; i < 200; i++) begin
            if (qa.size() == 0) break;
            @(posedge clk);
        end
        if (qa.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL a_timeout actual_left=%0d expected=0", qa.size());
            qa.delete();
        end
        #1;
        chk("a_in_ready_after", 66'(a_in_ready), 66'd1);
        chk("a_valid_after", 66'(a_out_valid), 66'd0);
    endtask

    task automatic wait_b;
        for (int i = 0; i < 200; i++) begin
            if (qb.size() == 0) break;
            @(posedge clk);
        end
        if (qb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL b_timeout actual_left=%0d expected=0", qb.size());
            qb.delete();
        end
        #1;
        chk("b_in_ready_after", 66'(b_in_ready), 66'd1);
        chk("b_valid_after", 66'(b_out_valid), 66'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        chk("rst_a_in_ready", 66'(a_in_ready), 66'd1);
        chk("rst_a_valid", 66'(a_out_valid), 66'd0);
        chk("rst_a_last", 66'(a_out_last), 66'd0);
        chk("rst_a_row", 66'(a_out_row), 66'd0);
        chk("rst_a_idx", 66'(a_out_row_idx), 66'd0);
        chk("rst_b_in_ready", 66'(b_in_ready), 66'd1);
        chk("rst_b_valid", 66'(b_out_valid), 66'd0);
        rst_n = 1'b1;

        // "07": tens blanked
        push_a(40'h00000FFFFF, 40'h000000001F, 40'h00000003E0,
               40'h0000007C00, 40'h00000F8000, 40'h00000F8000);
        send_a(8'h07);
        wait_a();

        // "10": both digits visible
        push_a(40'h003E007FE0, 40'h07FE0F801F, 40'hF83E0F801F,
               40'h003E0F801F, 40'h003E0F801F, 40'hFFFFF07FE0);
        send_a(8'h10);
        wait_a();

        // "00": single zero shown
        push_a(40'h0000007FE0, 40'h00000F801F, 40'h00000F801F,
               40'h00000F801F, 40'h00000F801F, 40'h0000007FE0);
        send_a(8'h00);
        wait_a();

        // "A5": code 10 blank, stall at idx 2
        push_a(40'h00000FFFFF, 40'h00000F8000, 40'h00000FFFE0,
               40'h000000001F, 40'h00000F801F, 40'h0000007FE0);
        send_a(8'hA5);
        @(posedge clk);
        @(posedge clk);
        #1;
        a_out_ready = 1'b0;
        chk("a_stall_start_idx", 66'(a_out_row_idx), 66'd2);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("a_stall_row", 66'(a_out_row), 66'h00000FFFE0);
            chk("a_stall_idx", 66'(a_out_row_idx), 66'd2);
            chk("a_stall_last", 66'(a_out_last), 66'd0);
            chk("a_stall_valid", 66'(a_out_valid), 66'd1);
            chk("a_stall_in_ready", 66'(a_in_ready), 66'd0);
        end
        @(posedge clk);
        #1;
        a_out_ready = 1'b1;
        wait_a();

        // "100" on 3-digit instance, in_valid pulsed mid-frame
        push_b(rb(20'h003E0, 20'h07FE0, 20'h07FE0),
               rb(20'h07FE0, 20'hF801F, 20'hF801F),
               rb(20'hF83E0, 20'hF801F, 20'hF801F),
               rb(20'h003E0, 20'hF801F, 20'hF801F),
               rb(20'h003E0, 20'hF801F, 20'hF801F),
               rb(20'hFFFFF, 20'h07FE0, 20'h07FE0));
        send_b(12'h100);
        @(posedge clk);
        #1;
        b_in_valid = 1'b1;
        b_in_bcd   = 12'h999;
        @(posedge clk);
        #1;
        chk("b_in_ready_busy", 66'(b_in_ready), 66'd0);
        b_in_valid = 1'b0;
        wait_b();

        // "0A7" without blanking: leading zero shown, A blank
        push_b(rb(20'h07FE0, 20'h00000, 20'hFFFFF),
               rb(20'hF801F, 20'h00000, 20'h0001F),
               rb(20'hF801F, 20'h00000, 20'h003E0),
               rb(20'hF801F, 20'h00000, 20'h07C00),
               rb(20'hF801F, 20'h00000, 20'hF8000),
               rb(20'h07FE0, 20'h00000, 20'hF8000));
        send_b(12'h0A7);
        wait_b();

        // Reset while idx 3 is presented
        qa.push_back('{66'(40'h00000FFFFF), 0});
        qa.push_back('{66'(40'h000000001F), 1});
        qa.push_back('{66'(40'h00000003E0), 2});
        send_a(8'h07);
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("a_pre_rst_idx", 66'(a_out_row_idx), 66'd3);
        chk("a_pre_rst_left", 66'(qa.size()), 66'd0);
        rst_n = 1'b0;
        #1;
        chk("a_mid_rst_valid", 66'(a_out_valid), 66'd0);
        chk("a_mid_rst_in_ready", 66'(a_in_ready), 66'd1);
        chk("a_mid_rst_row", 66'(a_out_row), 66'd0);
        chk("a_mid_rst_idx", 66'(a_out_row_idx), 66'd0);
        chk("a_mid_rst_last", 66'(a_out_last), 66'd0);
        #2;
        rst_n = 1'b1;
        qa.delete();

        push_a(40'h003E007FE0, 40'h07FE0F801F, 40'hF83E0F801F,
               40'h003E0F801F, 40'h003E0F801F, 40'hFFFFF07FE0);
        send_a(8'h10);
        wait_a();

        chk("a_queue_empty", 66'(qa.size()), 66'd0);
        chk("b_queue_empty", 66'(qb.size()), 66'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
